// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-RAM loader: FSM state encoding and
// word-geometry helpers.
package imem_loader_pkg;

   // Loader FSM states; encodings are fixed so debug taps can decode them.
   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StAssemble = 2'd1,
      StWrite    = 2'd2,
      StFinish   = 2'd3
   } loader_state_e;

   localparam int unsigned DefaultDataWidth = 32;
   localparam int unsigned DefaultAddrWidth = 10;

   // Number of stream bytes that make up one IRAM word.
   function automatic int unsigned bytes_per_word(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Byte-to-word packer: counts accepted bytes and assembles a little-endian word.
// o_word_out already contains the byte being pushed this cycle, so the caller can
// latch the complete word in the same cycle o_word_full is high.
module imem_byte_packer
   import imem_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   input  logic                  i_push,
   input  logic [7:0]            i_byte_in,
   output logic [DATA_WIDTH-1:0] o_word_out,
   output logic                  o_word_full
);

   localparam int unsigned BytesPerWord = bytes_per_word(DATA_WIDTH);
   localparam int unsigned IdxWidth     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;

   logic [IdxWidth-1:0]   r_idx;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  w_last;

   assign w_last      = (r_idx == IdxWidth'(BytesPerWord - 1));
   assign o_word_full = i_push && w_last;

   // New bytes enter at the top and shift down, so byte k ends up in [8k+7:8k].
   if (DATA_WIDTH > 8) begin : g_shift
      assign o_word_out = {i_byte_in, r_data[DATA_WIDTH-1:8]};
   end else begin : g_single
      assign o_word_out = i_byte_in;
   end

   // Byte index counter and partial-word register.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_idx  <= '0;
         r_data <= '0;
      end else if (i_push) begin
         if (w_last) begin
            r_idx  <= '0;
            r_data <= '0;
         end else begin
            r_idx  <= r_idx + IdxWidth'(1);
            r_data <= o_word_out;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-RAM write agent: packs a byte stream into words, writes them to
// consecutive IRAM addresses from 0, and holds the fetch stage while loading.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth,
   parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH:0]   i_word_count,
   input  logic [7:0]            i_byte_in,
   input  logic                  i_byte_valid,
   output logic                  o_byte_ready,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   output logic                  o_cpu_hold,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam logic [ADDR_WIDTH:0] MaxWords = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] OneWord  = (ADDR_WIDTH + 1)'(1);

   loader_state_e         r_state;
   logic [ADDR_WIDTH:0]   r_n;
   logic [ADDR_WIDTH:0]   r_words;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_accept;
   logic                  w_clr;
   logic [ADDR_WIDTH:0]   w_n;
   logic [DATA_WIDTH-1:0] w_word;
   logic                  w_word_full;

   assign o_byte_ready = (r_state == StAssemble);
   assign w_accept     = i_byte_valid && o_byte_ready;
   assign w_clr        = (r_state == StIdle) && i_start;
   // Loads longer than the RAM stop at the last address instead of wrapping.
   assign w_n          = (i_word_count > MaxWords) ? MaxWords : i_word_count;

   imem_byte_packer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_packer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clr       (w_clr),
      .i_push      (w_accept),
      .i_byte_in   (i_byte_in),
      .o_word_out  (w_word),
      .o_word_full (w_word_full)
   );

   // Loader FSM with registered IRAM write port and status outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_n     <= '0;
         r_words <= '0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_n     <= w_n;
                  r_words <= '0;
                  r_addr  <= '0;
                  r_done  <= 1'b0;
                  if (w_n == '0) begin
                     r_state <= StFinish;
                  end else begin
                     r_state <= StAssemble;
                     r_busy  <= 1'b1;
                  end
               end
            end
            StAssemble: begin
               if (w_word_full) begin
                  r_we    <= 1'b1;
                  r_wdata <= w_word;
                  r_state <= StWrite;
               end
            end
            StWrite: begin
               if (r_words + OneWord == r_n) begin
                  r_state <= StFinish;
               end else begin
                  r_words <= r_words + OneWord;
                  r_addr  <= r_addr + ADDR_WIDTH'(1);
                  r_state <= StAssemble;
               end
            end
            StFinish: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_mem_we    = r_we;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_busy      = r_busy;
   assign o_cpu_hold  = r_busy;
   assign o_done      = r_done;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver plans each load from a byte-level
// model and queues expected IRAM writes; a monitor checks every mem_we pulse.
module tb_imem_loader;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int Depth = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW:0]   word_count;
   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          cpu_hold;
   logic          busy;
   logic          done;

   imem_loader #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_word_count (word_count),
      .i_byte_in    (byte_in),
      .i_byte_valid (byte_valid),
      .o_byte_ready (byte_ready),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .o_cpu_hold   (cpu_hold),
      .o_busy       (busy),
      .o_done       (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         vectors = 0;
   int         miscompares = 0;
   int         exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   int         lat_q[$];
   logic [7:0] tx_q[$];
   int         wr_cnt = 0;
   int         last_addr = -1;
   logic       prev_we = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every write pulse must match the next planned write.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         chk("we_single_cycle", 64'(prev_we), 64'd0);
         if (exp_addr_q.size() == 0) begin
            chk("unexpected_we", 64'd1, 64'd0);
         end else begin
            chk("write_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
            chk("write_data", 64'(mem_wdata), 64'(exp_data_q.pop_front()));
         end
         if (lat_q.size() == 0) chk("we_latency_missing", 64'd1, 64'd0);
         else chk("we_latency", 64'(cyc), 64'(lat_q.pop_front()));
         chk("hold_busy_during_write", 64'({cpu_hold, busy}), 64'b11);
         wr_cnt++;
         last_addr = int'(mem_addr);
      end
      prev_we = mem_we;
   end

   // Model: one word's bytes enter the stream LSB first and land at addr.
   task automatic push_word(input int addr, input logic [31:0] word);
      for (int k = 0; k < 4; k++) tx_q.push_back(word[8*k +: 8]);
      exp_addr_q.push_back(addr);
      exp_data_q.push_back(word);
   endtask

   task automatic plan_random(input int wc);
      int n;
      n = (wc > Depth) ? Depth : wc;
      for (int i = 0; i < n; i++) push_word(i, $urandom);
   endtask

   task automatic do_start(input int wc);
      @(posedge clk);
      #1;
      start = 1'b1;
      word_count = (AW + 1)'(wc);
      @(posedge clk);
      #1;
      start = 1'b0;
      word_count = (AW + 1)'($urandom);
   endtask

   // Send count bytes from tx_q; gap<0 means random idle cycles before each byte.
   task automatic send(input int count, input int gap);
      int   g;
      int   waited;
      logic acc;
      for (int b = 0; b < count; b++) begin
         g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
         repeat (g) begin
            byte_valid = 1'b0;
            byte_in = 8'($urandom);
            @(posedge clk);
            #1;
         end
         byte_valid = 1'b1;
         byte_in = tx_q.pop_front();
         waited = 0;
         forever begin
            @(negedge clk);
            acc = byte_ready;
            if (acc && (b % 4 == 3)) lat_q.push_back(cyc + 1);
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 50) begin
               chk("byte_accept_timeout", 64'd0, 64'd1);
               byte_valid = 1'b0;
               return;
            end
         end
      end
      byte_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk("done_reached", 64'(ok), 64'd1);
      chk("idle_hold_busy", 64'({cpu_hold, busy}), 64'd0);
      chk("all_writes_seen", 64'(exp_addr_q.size()), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk(name, {byte_ready, mem_we, 6'(0), mem_addr, mem_wdata, cpu_hold, busy, done}, 64'd0);
   endtask

   int w0;
   int n;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      word_count = '0;
      byte_in = '0;
      byte_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset_outputs");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Two fixed words, back-to-back stream.
      push_word(0, 32'h1234_5678);
      push_word(1, 32'hDEAD_BEEF);
      w0 = wr_cnt;
      do_start(2);
      chk("busy_after_start", 64'({busy, cpu_hold, done}), 64'b110);
      send(8, 0);
      wait_done(100);
      chk("t1_write_count", 64'(wr_cnt - w0), 64'd2);

      // Same words with three idle cycles around every byte.
      push_word(0, 32'h1234_5678);
      push_word(1, 32'hDEAD_BEEF);
      w0 = wr_cnt;
      do_start(2);
      send(8, 3);
      wait_done(100);
      chk("t2_write_count", 64'(wr_cnt - w0), 64'd2);

      // Zero-length load: straight to done, never busy, no writes.
      w0 = wr_cnt;
      do_start(0);
      chk("zero_len_cycle1", 64'({done, busy}), 64'b00);
      @(posedge clk);
      #1;
      chk("zero_len_cycle2", 64'({done, busy}), 64'b10);
      repeat (4) @(posedge clk);
      chk("zero_len_no_write", 64'(wr_cnt - w0), 64'd0);

      // start pulse while busy is ignored; stream held across WRITE cycles.
      plan_random(3);
      w0 = wr_cnt;
      do_start(3);
      #1;
      start = 1'b1;
      word_count = (AW + 1)'(7);
      @(posedge clk);
      #1;
      start = 1'b0;
      send(12, 0);
      wait_done(100);
      chk("t6_write_count", 64'(wr_cnt - w0), 64'd3);

      // Reset after six bytes of a two-word load.
      plan_random(2);
      w0 = wr_cnt;
      do_start(2);
      send(6, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_outputs("mid_load_reset");
      chk("t5_write_count", 64'(wr_cnt - w0), 64'd1);
      chk("t5_pending_word", 64'(exp_addr_q.size()), 64'd1);
      exp_addr_q.delete();
      exp_data_q.delete();
      lat_q.delete();
      tx_q.delete();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      chk("t5_no_write_after_reset", 64'(wr_cnt - w0), 64'd1);
      plan_random(2);
      do_start(2);
      send(8, -1);
      wait_done(200);

      // Oversized count clamps to the full RAM depth.
      plan_random(Depth + 1);
      w0 = wr_cnt;
      do_start(Depth + 1);
      send(4 * Depth, 0);
      wait_done(100);
      chk("clamp_write_count", 64'(wr_cnt - w0), 64'(Depth));
      chk("clamp_last_addr", 64'(last_addr), 64'(Depth - 1));

      // Random short loads with random byte gaps.
      repeat (5) begin
         n = int'($urandom_range(1, 6));
         plan_random(n);
         w0 = wr_cnt;
         do_start(n);
         send(4 * n, -1);
         wait_done(200);
         chk("rand_write_count", 64'(wr_cnt - w0), 64'(n));
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
